pong_ctrl: RTL
==============

Name: pong_ctrl

Overview:
- Game-control and pixel-compositing core for the pong display pipeline. It sits between the pixel-producing objects (ball, paddles, background) and the VGA output.
- Generates a parametrised pixel-clock enable, replacing the fixed divide-by-two toggle.
- Composites object pixels into a COLOR_W-bit colour with per-object colours and fixed priority.
- Detects ball/paddle collisions and runs a serve/play/score/game-over state machine.

Parameters:
- CLK_DIV, 2: pixel enable period in clk cycles (>=1).
- COLOR_W, 8: output colour width.
- SCORE_W, 4: score counter width.
- WIN_SCORE, 9: points needed to win. Must be < 2**SCORE_W.
- SERVE_FRAMES, 60: frames the ball is held before each serve.
- BALL_COLOR, 8'hFF: ball colour.
- PADDLE_COLOR, 8'h1C: paddle colour.
- BG_COLOR, 8'hB6: background colour.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous, active-low reset
- pix_en  out  1  pixel-clock enable, high one clk per CLK_DIV
- vblank  in  1  vertical blank from vga_controller
- ball_valid  in  1  ball pixel at current hcount/vcount
- lpad_valid  in  1  left paddle pixel
- rpad_valid  in  1  right paddle pixel
- bg_valid  in  1  background pixel
- miss_left  in  1  ball passed left edge (pulse)
- miss_right  in  1  ball passed right edge (pulse)
- start  in  1  start/restart button, level
- rgb  out  COLOR_W  composited pixel colour
- ball_run  out  1  ball motion enable
- serve_dir  out  1  serve direction, 1 = toward right
- hit_left  out  1  left paddle collision pulse
- hit_right  out  1  right paddle collision pulse
- score_l  out  SCORE_W  left player score
- score_r  out  SCORE_W  right player score
- winner  out  2  00 none, 01 left, 10 right
- state  out  2  00 IDLE, 01 SERVE, 10 PLAY, 11 OVER

Behaviour:
- Reset (rst_n low at a clk edge) clears everything:
  - divider count = 0, pix_en = 0, rgb = 0
  - ball_run = 0, serve_dir = 1, hit_* = 0, scores = 0, winner = 00
  - state = IDLE, frame counter = 0, vblank_q = 0, start_q = 0, hit latches = 0
  - A reset mid-frame or mid-point fully restarts the game. Reset overrides pix_en.
- Divider: count runs 0..CLK_DIV-1 and wraps. pix_en is registered and is 1 in the cycle where count == CLK_DIV-1. With CLK_DIV=1, pix_en is 1 every cycle from the first cycle after reset.
- Enable qualification: all logic below updates only on clk edges where pix_en = 1. Inputs are sampled only on those edges.
- Compositor: registered, one-pixel latency. Priority, highest first:
  - ball_valid (suppressed in IDLE and OVER) -> BALL_COLOR
  - lpad_valid | rpad_valid -> PADDLE_COLOR
  - bg_valid -> BG_COLOR
  - otherwise 0
- Frame start: vblank_q tracks vblank. frame_start = vblank & ~vblank_q, i.e. the vblank rising edge.
- Start edge: start_q tracks start. start_rise = start & ~start_q. A held button causes exactly one action.
- Collision detection (PLAY only):
  - ball_valid & lpad_valid on the same sample sets the left hit latch and pulses hit_left.
  - hit_left is high for exactly one pixel period (the sample following detection), at most once per frame.
  - The latch clears on frame_start. hit_right is the same with rpad_valid.
- FSM transitions:
  - IDLE: start_rise -> SERVE, frame counter cleared.
  - SERVE: ball_run = 0. The counter increments on each frame_start. When counter reaches SERVE_FRAMES-1 and frame_start occurs -> PLAY. miss_* are ignored.
  - PLAY: ball_run = 1.
    - miss_left: score_r+1, serve_dir = 0.
    - miss_right: score_l+1, serve_dir = 1.
    - If the new score == WIN_SCORE -> OVER with winner set (10 right, 01 left); otherwise -> SERVE with counter cleared.
    - If miss_left and miss_right arrive on the same sample, only miss_left counts.
    - Score and hit on the same sample: both take effect.
  - OVER: ball_run = 0, scores held, winner held. start_rise clears scores and winner, sets serve_dir = 1, -> SERVE.
- Scores never exceed WIN_SCORE and never wrap.
- Outputs ball_run, serve_dir, scores, winner and state are registered and change only on pix_en edges.

Test Plan:
- CLK_DIV=3, release reset -> pix_en pattern 0,0,1,0,0,1...; with rst_n held low, rgb = 0, state = 00, scores = 0.
- ball_valid=1 and lpad_valid=1 and bg_valid=1 in PLAY -> rgb = 8'hFF one pix_en later; drop ball_valid -> 8'h1C; bg only -> 8'hB6; none -> 0; in IDLE with ball only -> 0.
- start pulse, SERVE_FRAMES=3 -> state goes 01, then 10 on the 3rd vblank rising edge; ball_run rises with it; start held high generates no further transitions.
- PLAY, ball_valid & rpad_valid for 5 consecutive pixels -> single one-pixel hit_right pulse; next frame overlap -> another single pulse.
- PLAY, miss_left and miss_right on the same sample -> score_r = 1, score_l = 0, serve_dir = 0, state = SERVE.
- WIN_SCORE=2, two miss_right events -> score_l = 2, winner = 01, state = OVER, ball_run = 0; start -> scores 0, winner 00, state SERVE; rst_n low mid-PLAY -> IDLE, all zeros.

Source files
------------

// File: rtl/pong_ctrl.sv
// Pong game control: pixel enable, colour compositor,
// paddle collision pulses and serve/play/score FSM.
module pong_ctrl #(
  parameter int CLK_DIV      = 2,
  parameter int COLOR_W      = 8,
  parameter int SCORE_W      = 4,
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_FRAMES = 60,
  parameter logic [COLOR_W-1:0] BALL_COLOR   = 8'hFF,
  parameter logic [COLOR_W-1:0] PADDLE_COLOR = 8'h1C,
  parameter logic [COLOR_W-1:0] BG_COLOR     = 8'hB6
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               pix_en,
  input  logic               vblank,
  input  logic               ball_valid,
  input  logic               lpad_valid,
  input  logic               rpad_valid,
  input  logic               bg_valid,
  input  logic               miss_left,
  input  logic               miss_right,
  input  logic               start,
  output logic [COLOR_W-1:0] rgb,
  output logic               ball_run,
  output logic               serve_dir,
  output logic               hit_left,
  output logic               hit_right,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic [1:0]         winner,
  output logic [1:0]         state
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int FW = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
  localparam logic [FW-1:0] FR_MAX = FW'(SERVE_FRAMES - 1);
  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SERVE = 2'b01,
    PLAY  = 2'b10,
    OVER  = 2'b11
  } state_t;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pix_en_q;

  state_t               state_q;
  logic [FW-1:0]        fcnt_q;
  logic [COLOR_W-1:0]   rgb_q, rgb_d;
  logic                 vblank_q, start_q;
  logic                 hl_lat_q, hr_lat_q;
  logic                 hit_l_q, hit_r_q;
  logic                 run_q, dir_q;
  logic [SCORE_W-1:0]   sl_q, sr_q;
  logic [1:0]           win_q;

  logic frame_start, start_rise, ball_vis, in_play;
  logic hl_eff, hr_eff, hl_det, hr_det;
  logic [SCORE_W-1:0] sl_inc, sr_inc;

  always_comb begin
    cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      pix_en_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      pix_en_q <= (cnt_d == CNT_MAX);
    end
  end

  always_comb begin
    frame_start = vblank & ~vblank_q;
    start_rise  = start & ~start_q;
    in_play     = (state_q == PLAY);
    ball_vis    = ball_valid & ((state_q == SERVE) | in_play);
    // a new frame re-arms the latch in the same sample
    hl_eff      = hl_lat_q & ~frame_start;
    hr_eff      = hr_lat_q & ~frame_start;
    hl_det      = in_play & ball_valid & lpad_valid & ~hl_eff;
    hr_det      = in_play & ball_valid & rpad_valid & ~hr_eff;
    sl_inc      = sl_q + SCORE_W'(1);
    sr_inc      = sr_q + SCORE_W'(1);
  end

  always_comb begin
    rgb_d = '0;
    priority case (1'b1)
      ball_vis:                rgb_d = BALL_COLOR;
      lpad_valid | rpad_valid: rgb_d = PADDLE_COLOR;
      bg_valid:                rgb_d = BG_COLOR;
      default:                 rgb_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      fcnt_q   <= '0;
      rgb_q    <= '0;
      vblank_q <= 1'b0;
      start_q  <= 1'b0;
      hl_lat_q <= 1'b0;
      hr_lat_q <= 1'b0;
      hit_l_q  <= 1'b0;
      hit_r_q  <= 1'b0;
      run_q    <= 1'b0;
      dir_q    <= 1'b1;
      sl_q     <= '0;
      sr_q     <= '0;
      win_q    <= 2'b00;
    end else if (pix_en_q) begin
      vblank_q <= vblank;
      start_q  <= start;
      rgb_q    <= rgb_d;
      hl_lat_q <= hl_eff | hl_det;
      hr_lat_q <= hr_eff | hr_det;
      hit_l_q  <= hl_det;
      hit_r_q  <= hr_det;
      unique case (state_q)
        IDLE: begin
          if (start_rise) begin
            state_q <= SERVE;
            fcnt_q  <= '0;
          end
        end
        SERVE: begin
          if (frame_start) begin
            if (fcnt_q == FR_MAX) begin
              state_q <= PLAY;
              run_q   <= 1'b1;
            end else begin
              fcnt_q <= fcnt_q + FW'(1);
            end
          end
        end
        PLAY: begin
          // left miss wins a tie with a simultaneous right miss
          if (miss_left) begin
            sr_q   <= sr_inc;
            dir_q  <= 1'b0;
            run_q  <= 1'b0;
            fcnt_q <= '0;
            if (sr_inc == WIN) begin
              state_q <= OVER;
              win_q   <= 2'b10;
            end else begin
              state_q <= SERVE;
            end
          end else if (miss_right) begin
            sl_q   <= sl_inc;
            dir_q  <= 1'b1;
            run_q  <= 1'b0;
            fcnt_q <= '0;
            if (sl_inc == WIN) begin
              state_q <= OVER;
              win_q   <= 2'b01;
            end else begin
              state_q <= SERVE;
            end
          end
        end
        OVER: begin
          if (start_rise) begin
            sl_q    <= '0;
            sr_q    <= '0;
            win_q   <= 2'b00;
            dir_q   <= 1'b1;
            fcnt_q  <= '0;
            state_q <= SERVE;
          end
        end
      endcase
    end
  end

  assign pix_en    = pix_en_q;
  assign rgb       = rgb_q;
  assign ball_run  = run_q;
  assign serve_dir = dir_q;
  assign hit_left  = hit_l_q;
  assign hit_right = hit_r_q;
  assign score_l   = sl_q;
  assign score_r   = sr_q;
  assign winner    = win_q;
  assign state     = state_q;

endmodule
